fft4_seq: RTL
=============

FFT4_SEQ -- requirements
Module: fft4_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_re (input, 8), in_im (input, 8): the sample input stream, signed two's complement.
REQ-004 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_re (output, 10), out_im (output, 10): the result stream, signed.
REQ-005 The block SHALL have port cnt0_out, output, 3 bits: the index sent to the twiddle generator.
REQ-006 The block SHALL have ports tw_re (input, 8) and tw_im (input, 8): the signed twiddle values returned combinationally for cnt0_out.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the state is CALC or UNLOAD.

Function
REQ-008 The block SHALL implement the states LOAD, CALC and UNLOAD, cycling LOAD -> CALC -> UNLOAD -> LOAD.
REQ-009 The block SHALL hold a 4-entry complex memory, mem[0..3], of 10-bit re/im words.
REQ-010 LOAD: in_ready=1; each in_valid&&in_ready writes the sign-extended sample to mem[k] for k=0,1,2,3 in order; after the 4th accept the block SHALL go to CALC the next cycle.
REQ-011 CALC SHALL last exactly 6 cycles, with cnt0_out=0..5 (one step per cycle) and in_ready=0.
REQ-012 Outside CALC, cnt0_out SHALL be 7.
REQ-013 At cnt0 0 and 1 the block SHALL do no memory update (pipeline/settle cycles).
REQ-014 Butterfly at step s on pair (a,b), using the twiddle for cnt0=s: mem[a] <= mem[a]+mem[b]; mem[b] <= (mem[a]-mem[b])*tw.
REQ-015 Pair schedule: cnt0=2 -> (0,2); 3 -> (1,3); 4 -> (0,1); 5 -> (2,3).
REQ-016 Complex multiply: re' = d_re*tw_re - d_im*tw_im; im' = d_re*tw_im + d_im*tw_re; 10x8 signed products, result truncated to the low 10 bits.
REQ-017 Arithmetic SHALL NOT saturate; inputs in [-128,127] do not overflow 10 bits.
REQ-018 After CALC, mem SHALL hold X0, X2, X1, X3 in entries 0..3 (bit-reversed order).
REQ-019 UNLOAD: out_valid=1 with out_re/out_im from the current read entry; the entry advances only on out_valid&&out_ready.
REQ-020 When out_ready=0, out_valid and the output data SHALL stay stable.
REQ-021 After the 4th output transfer the block SHALL go to LOAD the next cycle, with in_ready=1 in that cycle.
REQ-022 in_valid SHALL be ignored outside LOAD, and out_ready SHALL be ignored outside UNLOAD.

Reset
REQ-023 When rst=1 at a clock edge, from any state including mid-CALC or mid-UNLOAD, the block SHALL go to LOAD with the load count and read count cleared to 0.
REQ-024 Reset values SHALL be: in_ready=1, out_valid=0, out_re=0, out_im=0, cnt0_out=7, busy=0, and all mem entries 0.
REQ-025 A partial frame interrupted by reset SHALL be discarded.

Configuration
REQ-026 With macro FFT4_NATURAL_ORDER_EN defined, UNLOAD SHALL read entries 0,2,1,3, so outputs leave in order X0,X1,X2,X3.
REQ-027 Without FFT4_NATURAL_ORDER_EN, UNLOAD SHALL read entries 0,1,2,3, so outputs leave in order X0,X2,X1,X3.
REQ-028 Both builds SHALL have identical timing.

Verification
REQ-029 Bench SHALL drive input [1,0,0,0] (im=0) with out_ready=1 -> four outputs each (1,0).
REQ-030 Bench SHALL drive input [1,1,1,1] -> natural order (4,0),(0,0),(0,0),(0,0).
REQ-031 Bench SHALL drive input [0,1,0,0] with the macro defined -> (1,0),(0,-1),(-1,0),(0,1); without the macro -> (1,0),(-1,0),(0,-1),(0,1).
REQ-032 Bench SHALL drive all inputs (127,127) and then all (-128,-128) -> X0=(508,508), then X0=(-512,-512); all other outputs 0 and no wrap.
REQ-033 Bench SHALL hold out_ready=0 for 5 cycles in UNLOAD -> out_valid stays 1 and data stays constant; exactly 4 transfers occur after out_ready is released.
REQ-034 Bench SHALL assert rst at cnt0_out=3 -> next cycle LOAD, cnt0_out=7, out_valid=0; the next full frame gives correct results.

Source files
------------

// File: rtl/fft4_seq.sv
// Sequential 4-point radix-2 DIF FFT: load 4 samples, 6-cycle butterfly pass, unload 4 results.
// Optional build macro FFT4_NATURAL_ORDER_EN unloads in natural order X0,X1,X2,X3 instead of bit-reversed.
module fft4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_re,
    input  logic [7:0] in_im,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_re,
    output logic [9:0] out_im,
    output logic [2:0] cnt0_out,
    input  logic [7:0] tw_re,
    input  logic [7:0] tw_im,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CALC   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t     r_state;
    logic [9:0] r_mem_re [0:3];
    logic [9:0] r_mem_im [0:3];
    logic [1:0] r_ld_cnt;
    logic [1:0] r_rd_cnt;

    logic       w_bf_en;
    logic [1:0] w_idx_a;
    logic [1:0] w_idx_b;
    logic [9:0] w_sum_re;
    logic [9:0] w_sum_im;
    logic [9:0] w_diff_re;
    logic [9:0] w_diff_im;
    logic [9:0] w_tw_re_x;
    logic [9:0] w_tw_im_x;
    logic [9:0] w_mul_re;
    logic [9:0] w_mul_im;
    logic [1:0] w_next_rd;

    // Memory entry presented at output slot n of a frame.
    function automatic logic [1:0] rd_entry(input logic [1:0] n);
`ifdef FFT4_NATURAL_ORDER_EN
        return {n[0], n[1]};
`else
        return n;
`endif
    endfunction

    // Butterfly pair selection for the current CALC step.
    always_comb begin
        w_bf_en = 1'b0;
        w_idx_a = 2'd0;
        w_idx_b = 2'd0;
        if (r_state == ST_CALC) begin
            case (cnt0_out)
                3'd2: begin w_bf_en = 1'b1; w_idx_a = 2'd0; w_idx_b = 2'd2; end
                3'd3: begin w_bf_en = 1'b1; w_idx_a = 2'd1; w_idx_b = 2'd3; end
                3'd4: begin w_bf_en = 1'b1; w_idx_a = 2'd0; w_idx_b = 2'd1; end
                3'd5: begin w_bf_en = 1'b1; w_idx_a = 2'd2; w_idx_b = 2'd3; end
                default: begin w_bf_en = 1'b0; w_idx_a = 2'd0; w_idx_b = 2'd0; end
            endcase
        end else begin
            w_bf_en = 1'b0;
        end
    end

    // Butterfly datapath; only the low 10 bits of each product are kept, and those depend
    // only on the low 10 bits of the operands, so 10-bit wrapping arithmetic is exact here.
    always_comb begin
        w_sum_re  = r_mem_re[w_idx_a] + r_mem_re[w_idx_b];
        w_sum_im  = r_mem_im[w_idx_a] + r_mem_im[w_idx_b];
        w_diff_re = r_mem_re[w_idx_a] - r_mem_re[w_idx_b];
        w_diff_im = r_mem_im[w_idx_a] - r_mem_im[w_idx_b];
        w_tw_re_x = {{2{tw_re[7]}}, tw_re};
        w_tw_im_x = {{2{tw_im[7]}}, tw_im};
        w_mul_re  = (w_diff_re * w_tw_re_x) - (w_diff_im * w_tw_im_x);
        w_mul_im  = (w_diff_re * w_tw_im_x) + (w_diff_im * w_tw_re_x);
        w_next_rd = r_rd_cnt + 2'd1;
    end

    // Control FSM, sample memory and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_ld_cnt  <= 2'd0;
            r_rd_cnt  <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_re    <= 10'd0;
            out_im    <= 10'd0;
            cnt0_out  <= 3'd7;
            busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_mem_re[i] <= 10'd0;
                r_mem_im[i] <= 10'd0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r_mem_re[r_ld_cnt] <= {{2{in_re[7]}}, in_re};
                        r_mem_im[r_ld_cnt] <= {{2{in_im[7]}}, in_im};
                        if (r_ld_cnt == 2'd3) begin
                            r_state  <= ST_CALC;
                            r_ld_cnt <= 2'd0;
                            in_ready <= 1'b0;
                            cnt0_out <= 3'd0;
                            busy     <= 1'b1;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + 2'd1;
                        end
                    end
                end
                ST_CALC: begin
                    if (w_bf_en) begin
                        r_mem_re[w_idx_a] <= w_sum_re;
                        r_mem_im[w_idx_a] <= w_sum_im;
                        r_mem_re[w_idx_b] <= w_mul_re;
                        r_mem_im[w_idx_b] <= w_mul_im;
                    end
                    if (cnt0_out == 3'd5) begin
                        // The first output entry is final after step 4, so it can be read now.
                        r_state   <= ST_UNLOAD;
                        r_rd_cnt  <= 2'd0;
                        cnt0_out  <= 3'd7;
                        out_valid <= 1'b1;
                        out_re    <= r_mem_re[rd_entry(2'd0)];
                        out_im    <= r_mem_im[rd_entry(2'd0)];
                    end else begin
                        cnt0_out <= cnt0_out + 3'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (r_rd_cnt == 2'd3) begin
                            r_state   <= ST_LOAD;
                            r_rd_cnt  <= 2'd0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            r_rd_cnt <= w_next_rd;
                            out_re   <= r_mem_re[rd_entry(w_next_rd)];
                            out_im   <= r_mem_im[rd_entry(w_next_rd)];
                        end
                    end
                end
                default: begin
                    r_state   <= ST_LOAD;
                    r_ld_cnt  <= 2'd0;
                    r_rd_cnt  <= 2'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    cnt0_out  <= 3'd7;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
